// File: rtl/ps2_key_buffer_ctrl.sv
// ps2_key_buffer_ctrl
// Sequences a small PS/2 scancode shift buffer. Received bytes are decoded
// for E0/F0 prefixes; plain make codes are shifted into the buffer
// (sh_data + shren), the clear code empties it (del), and break/extended
// sequences are discarded. Buffer occupancy and a sticky overflow flag are
// tracked here.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   rx_byte   received byte, valid with rx_valid
//   rx_valid  one-cycle strobe, new byte
//   rx_err    one-cycle strobe, parity/framing error
//   sh_data   byte to shift, settles one cycle before shren
//   shren     one-cycle shift pulse
//   del       one-cycle clear pulse
//   count     entries held, 0..DEPTH
//   full      count == DEPTH
//   ovf       sticky, a make code was dropped because the buffer was full
//
// Optional feature: define PS2_REPEAT_FILTER_EN to drop typematic repeats of
// the most recently stored make code until its break code arrives.
module ps2_key_buffer_ctrl #(
  parameter int unsigned DEPTH    = 6,
  parameter logic [7:0]  CLR_CODE = 8'h76,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] sh_data,
  output logic       shren,
  output logic       del,
  output logic [3:0] count,
  output logic       full,
  output logic       ovf
);

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 16;
  localparam logic [7:0]    EXT_CODE = 8'hE0;
  localparam logic [7:0]    BRK_CODE = 8'hF0;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic          pend;
  logic          accept;
  logic          rep_hit;
  logic          is_plain;

  // A byte is taken only outside the two-cycle store window and without error.
  assign accept   = rx_valid && !rx_err && !pend && !shren;
  assign is_plain = (rx_byte != EXT_CODE) && (rx_byte != BRK_CODE) &&
                    (rx_byte != CLR_CODE);
  assign full     = (count == DEPTH_C);

`ifdef PS2_REPEAT_FILTER_EN
  logic       held;
  logic [7:0] held_code;

  assign rep_hit = held && (rx_byte == held_code);

  // Remembers the last stored make code until its break, a clear or an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held      <= 1'b0;
      held_code <= 8'h00;
    end else if (rx_err) begin
      held <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (rx_byte == CLR_CODE) begin
            held <= 1'b0;
          end else if (is_plain && !rep_hit && !full) begin
            held      <= 1'b1;
            held_code <= rx_byte;
          end
        end
        BRK: begin
          if (rep_hit) held <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  // Prefix decode FSM, store/clear sequencing, occupancy and timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      to_cnt  <= '0;
      pend    <= 1'b0;
      sh_data <= 8'h00;
      shren   <= 1'b0;
      del     <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      shren <= 1'b0;
      del   <= 1'b0;

      // Second half of a store: sh_data has been stable for a cycle.
      if (pend) begin
        pend  <= 1'b0;
        shren <= 1'b1;
        if (count != DEPTH_C) count <= count + CW'(1);
      end

      if (rx_err) begin
        state  <= IDLE;
        to_cnt <= '0;
      end else if (accept) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (rx_byte == EXT_CODE) begin
              state <= EXT;
            end else if (rx_byte == BRK_CODE) begin
              state <= BRK;
            end else if (rx_byte == CLR_CODE) begin
              del   <= 1'b1;
              count <= '0;
              ovf   <= 1'b0;
            end else if (!rep_hit) begin
              if (full) begin
                ovf <= 1'b1;
              end else begin
                sh_data <= rx_byte;
                pend    <= 1'b1;
              end
            end
          end
          BRK:     state <= IDLE;
          EXT:     state <= (rx_byte == BRK_CODE) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // Abandon a prefix whose follow-up byte never arrives.
        if (rx_valid) begin
          to_cnt <= '0;
        end else if (to_cnt == TO_LAST) begin
          state  <= IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_buffer_ctrl.sv
// Directed bench for ps2_key_buffer_ctrl: reset, store latency, prefix
// decoding, overflow/clear, prefix timeout, error recovery, repeat filter.
module tb_ps2_key_buffer_ctrl;

  localparam int unsigned TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] sh_data;
  logic       shren;
  logic       del;
  logic [3:0] count;
  logic       full;
  logic       ovf;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int v_cyc     = 0;
  int shren_cnt = 0;
  int del_cnt   = 0;
  int last_lat  = 0;
  logic [7:0] last_data = 8'h00;

  ps2_key_buffer_ctrl #(.DEPTH(6), .CLR_CODE(8'h76), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_err(rx_err), .sh_data(sh_data), .shren(shren), .del(del),
    .count(count), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (shren) begin
      shren_cnt = shren_cnt + 1;
      last_data = sh_data;
      last_lat  = cyc - v_cyc;
    end
    if (del) del_cnt = del_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    rx_err   = err;
    v_cyc    = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_err();
    @(negedge clk);
    rx_err = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s0;
    int d0;
    logic [7:0] codes [7];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C};
    rst = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", int'({sh_data, shren, del, count, full, ovf}), 0);

    // Reset asserted after sh_data updates but before shren fires.
    @(negedge clk);
    rx_byte = 8'h1C; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("presetup_sh_data", int'(sh_data), 'h1C);
    check("presetup_shren", int'(shren), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midstore_reset_shren", shren_cnt, 0);
    check("midstore_reset_outputs", int'({sh_data, shren, del, count, full, ovf}), 0);

    // Make, break, make.
    s0 = shren_cnt;
    send(8'h1C, 1'b0);
    check("store1_data", int'(last_data), 'h1C);
    check("store1_latency", last_lat, 2);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h32, 1'b0);
    check("store2_data", int'(last_data), 'h32);
    check("store2_latency", last_lat, 2);
    check("break_pulses", shren_cnt - s0, 2);
    check("break_count", int'(count), 2);

    // Clear, then fill past capacity, then clear again.
    d0 = del_cnt;
    send(8'h76, 1'b0);
    check("clear1_del", del_cnt - d0, 1);
    check("clear1_count", int'(count), 0);
    s0 = shren_cnt;
    for (int i = 0; i < 6; i++) send(codes[i], 1'b0);
    check("fill_pulses", shren_cnt - s0, 6);
    check("fill_full", int'({full, ovf}), 'b10);
    check("fill_last_data", int'(last_data), 'h35);
    send(codes[6], 1'b0);
    check("ovf_pulses", shren_cnt - s0, 6);
    check("ovf_flags", int'({count, full, ovf}), 'b0110_11);
    d0 = del_cnt;
    send(8'h76, 1'b0);
    check("clear2_del", del_cnt - d0, 1);
    check("clear2_flags", int'({count, full, ovf}), 0);

    // Extended make and break are discarded.
    s0 = shren_cnt;
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    send(8'h1C, 1'b0);
    check("ext_pulses", shren_cnt - s0, 1);
    check("ext_data", int'(last_data), 'h1C);
    check("ext_count", int'(count), 1);

    // Break code arriving before timeout is discarded.
    s0 = shren_cnt;
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    check("brk_discard", shren_cnt - s0, 0);

    // Prefix times out, next byte is a make.
    send(8'hF0, 1'b0);
    repeat (TO + 2) @(negedge clk);
    send(8'h1C, 1'b0);
    check("timeout_pulses", shren_cnt - s0, 1);
    check("timeout_count", int'(count), 2);

    // Error aborts prefix.
    s0 = shren_cnt;
    send(8'hF0, 1'b0);
    send_err();
    send(8'h1C, 1'b0);
    check("err_pulses", shren_cnt - s0, 1);
    check("err_count", int'(count), 3);

    // Error in the same cycle as a valid byte drops the byte.
    s0 = shren_cnt;
    send(8'h32, 1'b1);
    check("err_valid_drop", shren_cnt - s0, 0);
    check("err_valid_count", int'(count), 3);

    // Typematic repeat sequence.
    send(8'h76, 1'b0);
    s0 = shren_cnt;
    send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
`ifdef PS2_REPEAT_FILTER_EN
    check("repeat_pulses", shren_cnt - s0, 2);
    check("repeat_count", int'(count), 2);
`else
    check("repeat_pulses", shren_cnt - s0, 4);
    check("repeat_count", int'(count), 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
